// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm sequencer: match detect, ring, snooze, dismiss, auto-timeout
module alarm_controller #(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       alarm_en,
    input  logic       snooze,
    input  logic       dismiss,
    input  logic [1:0] TH1,
    input  logic [3:0] TH2,
    input  logic [2:0] TM1,
    input  logic [3:0] TM2,
    input  logic [1:0] AH1,
    input  logic [3:0] AH2,
    input  logic [2:0] AM1,
    input  logic [3:0] AM2,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzzer,
    output logic       led_alarm,
    output logic [1:0] snooze_cnt
);

    localparam int RW = $clog2(RING_TIMEOUT_SEC + 1);
    localparam int SW = $clog2(SNOOZE_SEC + 1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT_SEC - 1);
    localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_SEC);
    localparam logic [1:0]    SNZ_MAX   = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

    state_t        state, state_n;
    logic          blink, blink_n;
    logic [RW-1:0] ring_tmr, ring_tmr_n;
    logic [SW-1:0] snz_tmr, snz_tmr_n;
    logic [1:0]    snz_cnt_n;
    logic          match, match_q, trigger;

    assign match   = alarm_en & ({TH1, TH2, TM1, TM2} == {AH1, AH2, AM1, AM2});
    assign trigger = match & ~match_q;

    // match_q powers up high so a reset inside the alarm minute does not ring
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            blink      <= 1'b0;
            ring_tmr   <= '0;
            snz_tmr    <= '0;
            snooze_cnt <= '0;
            match_q    <= 1'b1;
        end else begin
            state      <= state_n;
            blink      <= blink_n;
            ring_tmr   <= ring_tmr_n;
            snz_tmr    <= snz_tmr_n;
            snooze_cnt <= snz_cnt_n;
            match_q    <= match;
        end
    end

    always_comb begin
        state_n    = state;
        blink_n    = blink;
        ring_tmr_n = ring_tmr;
        snz_tmr_n  = snz_tmr;
        snz_cnt_n  = snooze_cnt;
        if (!alarm_en) begin
            state_n = IDLE;
            blink_n = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trigger) begin
                        state_n    = RINGING;
                        ring_tmr_n = '0;
                        blink_n    = 1'b1;
                        snz_cnt_n  = '0;
                    end
                end
                RINGING: begin
                    if (dismiss) begin
                        state_n = IDLE;
                        blink_n = 1'b0;
                    end else if (snooze) begin
                        // a snooze past the limit is swallowed and the tick is still dropped
                        if (snooze_cnt < SNZ_MAX) begin
                            state_n   = SNOOZE;
                            snz_tmr_n = SNZ_LOAD;
                            snz_cnt_n = snooze_cnt + 2'd1;
                        end
                    end else if (sec_tick) begin
                        if (ring_tmr == RING_LAST) begin
                            state_n = IDLE;
                            blink_n = 1'b0;
                        end else begin
                            blink_n    = ~blink;
                            ring_tmr_n = ring_tmr + 1'b1;
                        end
                    end
                end
                SNOOZE: begin
                    if (dismiss) begin
                        state_n = IDLE;
                        blink_n = 1'b0;
                    end else if (snooze) begin
                        state_n = SNOOZE;
                    end else if (sec_tick) begin
                        if (snz_tmr <= SW'(1)) begin
                            state_n    = RINGING;
                            ring_tmr_n = '0;
                            blink_n    = 1'b1;
                            snz_tmr_n  = '0;
                        end else begin
                            snz_tmr_n = snz_tmr - 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    blink_n = 1'b0;
                end
            endcase
        end
    end

    assign ringing  = (state == RINGING);
    assign snoozing = (state == SNOOZE);
    assign buzzer   = ringing & blink;

    always_comb begin
        led_alarm = alarm_en;
        if (state == RINGING)     led_alarm = blink;
        else if (state == SNOOZE) led_alarm = 1'b1;
    end

endmodule
